// File: rtl/instr_aligner.sv
// instr_aligner: realigns 32-bit fetch words into a stream of 16/32-bit instructions.
// A 4-halfword queue absorbs fetch words. A small RUN/SKIP FSM drops the unused low
// half of the first word after a redirect to an odd-halfword PC.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fw_valid,
    output logic        fw_ready,
    input  logic [31:0] fw_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic        instr_is_comp,
    output logic [31:0] instr_pc
);

    typedef enum logic {RUN = 1'b0, SKIP = 1'b1} state_t;

    state_t           state, state_next;
    logic [3:0][15:0] q, q_next;       // q[0] is the oldest halfword
    logic [2:0]       count, count_next;
    logic [31:0]      head_pc;
    logic             alive;           // low until the first edge after reset release

    logic             head_comp;
    logic             push, push_one, push_two;
    logic [2:0]       pop_n, push_n, base;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    // Next state: redirect picks the phase, a SKIP push completes the odd-halfword entry
    always_comb begin
        state_next = state;
        if (flush)                        state_next = flush_pc[1] ? SKIP : RUN;
        else if (push && state == SKIP)   state_next = RUN;
    end

    // Output decode from the queue head and handshake bookkeeping
    always_comb begin
        head_comp     = (q[0][1:0] != 2'b11);
        instr_valid   = !flush && (head_comp ? (count >= 3'd1) : (count >= 3'd2));
        fw_ready      = alive && (count <= 3'd2) && !flush;
        instr_is_comp = instr_valid && head_comp;
        instr_pc      = head_pc;
        instr_data    = 32'h0;
        if (instr_valid) instr_data = head_comp ? {16'h0, q[0]} : {q[1], q[0]};
        push     = fw_valid && fw_ready;
        push_one = push && (state == SKIP);
        push_two = push && (state == RUN);
        pop_n    = (instr_valid && instr_ready) ? (head_comp ? 3'd1 : 3'd2) : 3'd0;
        push_n   = push_two ? 3'd2 : (push_one ? 3'd1 : 3'd0);
    end

    // Queue next value: shift out popped halfwords, then append pushed ones behind survivors
    always_comb begin
        case (pop_n)
            3'd1:    q_next = {16'h0, q[3], q[2], q[1]};
            3'd2:    q_next = {16'h0, 16'h0, q[3], q[2]};
            default: q_next = q;
        endcase
        base = count - pop_n;
        for (int i = 0; i < 4; i++) begin
            if (push_one && base == 3'(i))         q_next[i] = fw_data[31:16];
            if (push_two && base == 3'(i))         q_next[i] = fw_data[15:0];
            if (push_two && base + 3'd1 == 3'(i))  q_next[i] = fw_data[31:16];
        end
        count_next = count + push_n - pop_n;
    end

    // Queue, count and PC registers; flush overrides any push/pop in its cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= '0;
            count   <= 3'd0;
            head_pc <= RESET_PC;
            alive   <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                q       <= '0;
                count   <= 3'd0;
                head_pc <= {flush_pc[31:1], 1'b0};
            end else begin
                q       <= q_next;
                count   <= count_next;
                head_pc <= head_pc + {28'h0, pop_n, 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: a halfword-queue reference model predicts every cycle's
// outputs; directed scenarios then check emitted instructions against fixed values.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        reset_n, flush, fw_valid, instr_ready;
    logic [31:0] flush_pc, fw_data;
    logic        fw_ready, instr_valid, instr_is_comp;
    logic [31:0] instr_data, instr_pc;

    int tests = 0;
    int failed = 0;

    // reference model state
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mskip, malive;
    int          mpushed;

    // log of instructions the DUT actually handed over
    logic [31:0] log_d[$];
    logic [31:0] log_pc[$];

    always #5 clk = ~clk;

    instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
        .fw_valid(fw_valid), .fw_ready(fw_ready), .fw_data(fw_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_is_comp(instr_is_comp), .instr_pc(instr_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lgd(input int i);
        return (i < log_d.size()) ? log_d[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] lgp(input int i);
        return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: compare DUT against model, then advance both past the edge
    task automatic tick();
        logic [15:0] h0, h1;
        logic        ecomp, ev, er;
        logic [31:0] edata;
        #1;
        h0    = (mq.size() > 0) ? mq[0] : 16'h0;
        h1    = (mq.size() > 1) ? mq[1] : 16'h0;
        ecomp = (h0[1:0] != 2'b11);
        ev    = !flush && (ecomp ? (mq.size() >= 1) : (mq.size() >= 2));
        er    = malive && (mq.size() <= 2) && !flush;
        edata = !ev ? 32'h0 : (ecomp ? {16'h0, h0} : {h1, h0});
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, ev});
        chk("fw_ready", {31'h0, fw_ready}, {31'h0, er});
        chk("instr_data", instr_data, edata);
        chk("instr_is_comp", {31'h0, instr_is_comp}, {31'h0, ev && ecomp});
        chk("instr_pc", instr_pc, mpc);
        if (instr_valid && instr_ready) begin
            log_d.push_back(instr_data);
            log_pc.push_back(instr_pc);
        end
        if (flush) begin
            mq.delete();
            mpc   = {flush_pc[31:1], 1'b0};
            mskip = flush_pc[1];
        end else begin
            if (ev && instr_ready) begin
                void'(mq.pop_front());
                if (!ecomp) void'(mq.pop_front());
                mpc = mpc + (ecomp ? 32'd2 : 32'd4);
            end
            if (fw_valid && er) begin
                if (mskip) begin
                    mq.push_back(fw_data[31:16]);
                    mpushed += 1;
                end else begin
                    mq.push_back(fw_data[15:0]);
                    mq.push_back(fw_data[31:16]);
                    mpushed += 2;
                end
                mskip = 1'b0;
            end
        end
        malive = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop immediately
    task automatic do_reset();
        fw_valid = 1'b0;
        flush    = 1'b0;
        reset_n  = 1'b0;
        #1;
        mq.delete();
        mpc    = 32'h0;
        mskip  = 1'b0;
        malive = 1'b0;
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_fw_ready", {31'h0, fw_ready}, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_is_comp", {31'h0, instr_is_comp}, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; flush = 1'b0; flush_pc = 32'h0;
        fw_valid = 1'b0; fw_data = 32'h0; instr_ready = 1'b1;
        mpushed = 0; mskip = 1'b0; malive = 1'b0; mpc = 32'h0;
        #2;

        // 1: single 32-bit addi
        do_reset();
        tick();
        log_d.delete(); log_pc.delete();
        fw_valid = 1'b1; fw_data = 32'h00A0_0093; tick();
        fw_valid = 1'b0; tick();
        chk("t1_data", lgd(0), 32'h00A0_0093);
        chk("t1_pc", lgp(0), 32'h0);

        // 2: two compressed c.li in one word
        log_d.delete(); log_pc.delete();
        do_reset(); tick();
        fw_valid = 1'b1; fw_data = 32'h4505_4485; tick();
        fw_valid = 1'b0; tick(); tick();
        chk("t2_data0", lgd(0), 32'h0000_4485);
        chk("t2_pc0", lgp(0), 32'h0);
        chk("t2_data1", lgd(1), 32'h0000_4505);
        chk("t2_pc1", lgp(1), 32'h2);

        // 3: 32-bit instruction straddling two words, with a stall before the second word
        log_d.delete(); log_pc.delete();
        do_reset(); tick();
        fw_valid = 1'b1; fw_data = 32'h0093_4485; tick();
        fw_valid = 1'b0; tick(); tick();      // only low half of addi buffered
        fw_valid = 1'b1; fw_data = 32'h1234_00A0; tick();
        fw_valid = 1'b0; tick();
        instr_ready = 1'b0; tick();           // residual 1234 held at pc 6
        instr_ready = 1'b1; tick();
        chk("t3_data0", lgd(0), 32'h0000_4485);
        chk("t3_data1", lgd(1), 32'h00A0_0093);
        chk("t3_pc1", lgp(1), 32'h2);
        chk("t3_data2", lgd(2), 32'h0000_1234);
        chk("t3_pc2", lgp(2), 32'h6);

        // 4: redirect to odd halfword; low half of the first word is discarded
        log_d.delete(); log_pc.delete();
        flush = 1'b1; flush_pc = 32'h0000_0102; fw_valid = 1'b1; fw_data = 32'h0;
        tick();
        flush = 1'b0; fw_data = 32'h4505_FFFF; tick();
        fw_valid = 1'b0; tick(); tick();
        chk("t4_count", log_d.size(), 32'd1);
        chk("t4_data", lgd(0), 32'h0000_4505);
        chk("t4_pc", lgp(0), 32'h0000_0102);

        // 5: back-pressure; fw_ready must drop and nothing is lost or duplicated
        log_d.delete(); log_pc.delete();
        mpushed = 0;
        instr_ready = 1'b0;
        fw_valid = 1'b1; fw_data = 32'h4401_4485; tick();
        fw_data = 32'h4505_4409; tick();
        fw_data = 32'h4511_4515; tick(); tick();
        fw_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_pushed", mpushed, 32'd4);
        chk("t5_emitted", log_d.size(), 32'd4);
        chk("t5_last", lgd(3), 32'h0000_4505);

        // 6: reset with three halfwords buffered
        instr_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h0000_0202; tick();
        flush = 1'b0; fw_valid = 1'b1; fw_data = 32'h4485_0000; tick();
        fw_data = 32'h4505_4485; tick();
        fw_valid = 1'b0; instr_ready = 1'b1;
        do_reset();
        log_d.delete(); log_pc.delete();
        tick();
        fw_valid = 1'b1; fw_data = 32'h00A0_0093; tick();
        fw_valid = 1'b0; tick();
        chk("t6_pc", lgp(0), 32'h0);
        chk("t6_data", lgd(0), 32'h00A0_0093);

        // random traffic with occasional redirects, including straight 32-bit streaming
        for (int i = 0; i < 600; i++) begin
            fw_valid    = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            fw_data     = $urandom;
            if ($urandom_range(0, 1) == 0) fw_data[1:0] = 2'b11;
            flush       = ($urandom_range(0, 31) == 0);
            flush_pc    = $urandom;
            if (i >= 500) begin
                fw_valid = 1'b1; instr_ready = 1'b1; flush = 1'b0;
                fw_data[1:0] = 2'b11;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
